// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Constants shared by the invaders game blocks (screen limits, ship hit-box,
// lives default, coordinate width) and the projectile pool FSM encoding.
// Modules override the *_DEF values through their own parameters.
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int COORD_W_DEF = 10;   // 640x480 screen fits in 10 bits
  localparam int X_MAX_DEF   = 639;  // last visible column
  localparam int Y_MAX_DEF   = 479;  // last visible row
  localparam int SHIP_W_DEF  = 45;   // ship hit-box width
  localparam int SHIP_H_DEF  = 20;   // ship hit-box height
  localparam int LIVES_DEF   = 3;    // lives loaded at reset/restart

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_SCAN = 2'd2
  } pool_state_t;

endpackage

// File: rtl/free_slot_enc.sv
// ---------------------------------------------------------------------------
// free_slot_enc
// Lowest-zero priority encoder: returns the index of the lowest clear bit of
// the slot-occupancy mask and whether any slot is free.
// Ports:
//   i_used      occupancy mask, bit i = slot i in use
//   o_idx       index of the lowest free slot (0 when none free)
//   o_any_free  at least one slot is free
// ---------------------------------------------------------------------------
module free_slot_enc
  import game_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int IDX_W   = 3
) (
  input  logic [N_SLOTS-1:0] i_used,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any_free
);

  // Scan from the top down so the lowest free index is written last.
  always_comb begin
    o_idx      = '0;
    o_any_free = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!i_used[i]) begin
        o_idx      = IDX_W'(i);
        o_any_free = 1'b1;
      end else begin
        o_any_free = o_any_free;
      end
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// ---------------------------------------------------------------------------
// projectile_pool
// Pool of N_SLOTS projectiles: allocation, timed motion, despawn at the
// screen edges, ship hit detection, lives counter and game-over flag.
// Optional feature macro: PROJ_LIVES_EN (lives counter and perdeu; without
// it vidas stays at LIVES, perdeu is 0 and motion never stops).
// Ports:
//   CLOCK_50, reset     clock, asynchronous active-high reset
//   pausa, reiniciar    freeze ticks/spawns; one-cycle synchronous restart
//   spawn_*             spawn handshake and start position/direction
//   ship_x, ship_y      ship hit-box top-left corner
//   proj_x/y/active     packed per-slot position and valid mask
//   hit_pulse           one cycle per ship hit
//   vidas, perdeu       remaining lives, sticky game-over
// ---------------------------------------------------------------------------
module projectile_pool
  import game_pkg::*;
#(
  parameter int N_SLOTS  = 8,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int TICK_DIV = 320000,
  parameter int SPEED    = 2,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int SHIP_W   = SHIP_W_DEF,
  parameter int SHIP_H   = SHIP_H_DEF,
  parameter int LIVES    = LIVES_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         pausa,
  input  logic                         reiniciar,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [COORD_W-1:0]           spawn_x,
  input  logic [COORD_W-1:0]           spawn_y,
  input  logic                         spawn_up,
  input  logic [COORD_W-1:0]           ship_x,
  input  logic [COORD_W-1:0]           ship_y,
  output logic [N_SLOTS*COORD_W-1:0]   proj_x,
  output logic [N_SLOTS*COORD_W-1:0]   proj_y,
  output logic [N_SLOTS-1:0]           proj_active,
  output logic                         hit_pulse,
  output logic [1:0]                   vidas,
  output logic                         perdeu
);

  localparam int IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0]  TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_SLOTS - 1);
  // Edge and box comparisons use one extra bit so sums cannot wrap.
  localparam logic [COORD_W:0]   SPEED_X   = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0]   Y_MAX_X   = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W:0]   SHIP_W_X  = (COORD_W+1)'(SHIP_W);
  localparam logic [COORD_W:0]   SHIP_H_X  = (COORD_W+1)'(SHIP_H);
  localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'(SPEED);
  localparam logic [1:0]         LIVES_C   = 2'(LIVES);

  pool_state_t                      r_state, w_state_next;
  logic [IDX_W-1:0]                 r_idx;
  logic [TCNT_W-1:0]                r_tick_cnt;
  logic                             r_tick_pend, w_run, w_tick_wrap;
  logic [N_SLOTS-1:0][COORD_W-1:0]  r_x, r_y, w_y_mv;
  logic [N_SLOTS-1:0]               r_up, r_active, w_gone;
  logic [IDX_W-1:0]                 w_free_idx;
  logic                             w_any_free, w_spawn_ready, w_spawn_fire;
  logic                             w_hit, r_hit_pulse;
  logic [COORD_W:0]                 w_scan_x, w_scan_y, w_box_x, w_box_y;
  logic [1:0]                       w_vidas;
  logic                             w_perdeu;

  free_slot_enc #(.N_SLOTS(N_SLOTS), .IDX_W(IDX_W)) u_free_slot_enc (
    .i_used     (r_active),
    .o_idx      (w_free_idx),
    .o_any_free (w_any_free)
  );

  assign w_run       = !pausa && !w_perdeu;
  assign w_tick_wrap = w_run && (r_tick_cnt == TICK_LAST);

  // Reset/restart force ready low so nothing is accepted while clearing.
  assign w_spawn_ready = (r_state == ST_IDLE) && !pausa && !w_perdeu && !r_tick_pend &&
                         w_any_free && !w_tick_wrap && !reset && !reiniciar;
  assign w_spawn_fire  = spawn_valid && w_spawn_ready;

  assign w_scan_x = {1'b0, r_x[r_idx]};
  assign w_scan_y = {1'b0, r_y[r_idx]};
  assign w_box_x  = {1'b0, ship_x};
  assign w_box_y  = {1'b0, ship_y};
  // Only enemy (downward) shots can hit the ship.
  assign w_hit = (r_state == ST_SCAN) && r_active[r_idx] && !r_up[r_idx] &&
                 (w_scan_x >= w_box_x) && (w_scan_x < w_box_x + SHIP_W_X) &&
                 (w_scan_y >= w_box_y) && (w_scan_y < w_box_y + SHIP_H_X);

  // Motion tick divider and pending-tick flag.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_tick_pend <= 1'b0;
    end else if (reiniciar) begin
      r_tick_cnt  <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      if (w_run) r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + TCNT_W'(1);
      if (w_tick_wrap)                            r_tick_pend <= 1'b1;
      else if (r_state == ST_IDLE && r_tick_pend) r_tick_pend <= 1'b0;
    end
  end

  // FSM state register and scan index.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else if (reiniciar) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= (r_state == ST_SCAN) ? r_idx + IDX_W'(1) : '0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (r_tick_pend) w_state_next = ST_MOVE; else w_state_next = ST_IDLE;
      ST_MOVE: w_state_next = ST_SCAN;
      ST_SCAN: if (r_idx == IDX_LAST) w_state_next = ST_IDLE; else w_state_next = ST_SCAN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-slot moved position and despawn decision; up shots must not underflow.
  always_comb begin
    w_y_mv = '0;
    w_gone = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (r_up[i]) begin
        w_gone[i] = ({1'b0, r_y[i]} < SPEED_X);
        w_y_mv[i] = r_y[i] - SPEED_C;
      end else begin
        w_gone[i] = (({1'b0, r_y[i]} + SPEED_X) > Y_MAX_X);
        w_y_mv[i] = r_y[i] + SPEED_C;
      end
    end
  end

  // Slot storage: spawn load, motion, hit clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_x <= '0; r_y <= '0; r_up <= '0; r_active <= '0;
    end else if (reiniciar) begin
      r_x <= '0; r_y <= '0; r_up <= '0; r_active <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_spawn_fire) begin
            r_x[w_free_idx]      <= spawn_x;
            r_y[w_free_idx]      <= spawn_y;
            r_up[w_free_idx]     <= spawn_up;
            r_active[w_free_idx] <= 1'b1;
          end
        end
        ST_MOVE: begin
          for (int i = 0; i < N_SLOTS; i++) begin
            if (r_active[i]) begin
              if (w_gone[i]) r_active[i] <= 1'b0;
              else           r_y[i]      <= w_y_mv[i];
            end
          end
        end
        ST_SCAN: if (w_hit) r_active[r_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Hit pulse follows the scanned slot by one cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)          r_hit_pulse <= 1'b0;
    else if (reiniciar) r_hit_pulse <= 1'b0;
    else                r_hit_pulse <= w_hit;
  end

`ifdef PROJ_LIVES_EN
  logic [1:0] r_vidas;
  logic       r_perdeu;

  // Lives counter, saturating at zero; game-over latches on the last life.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_vidas  <= LIVES_C;
      r_perdeu <= 1'b0;
    end else if (reiniciar) begin
      r_vidas  <= LIVES_C;
      r_perdeu <= 1'b0;
    end else if (w_hit && (r_vidas != 2'd0)) begin
      r_vidas <= r_vidas - 2'd1;
      if (r_vidas == 2'd1) r_perdeu <= 1'b1;
    end
  end

  assign w_vidas  = r_vidas;
  assign w_perdeu = r_perdeu;
`else
  assign w_vidas  = LIVES_C;
  assign w_perdeu = 1'b0;
`endif

  assign spawn_ready = w_spawn_ready;
  assign proj_x      = r_x;
  assign proj_y      = r_y;
  assign proj_active = r_active;
  assign hit_pulse   = r_hit_pulse;
  assign vidas       = w_vidas;
  assign perdeu      = w_perdeu;

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: table-driven motion vectors, hand-written
// corner sequences and randomized rounds checked against a slot-level model.
module tb_projectile_pool;
  localparam int N = 8, W = 10, TD = 16, SPD = 2, YM = 479, SW = 45, SH = 20, LV = 3;
`ifdef PROJ_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic clk = 1'b0, rst, pausa, rein, sv, sup;
  logic [W-1:0] sx, sy, shx, shy;
  wire sready, hp, perd;
  wire [N*W-1:0] px, py;
  wire [N-1:0] pact;
  wire [1:0] vid;

  projectile_pool #(.N_SLOTS(N), .COORD_W(W), .TICK_DIV(TD), .SPEED(SPD), .Y_MAX(YM),
                    .SHIP_W(SW), .SHIP_H(SH), .LIVES(LV)) dut (
    .CLOCK_50(clk), .reset(rst), .pausa(pausa), .reiniciar(rein),
    .spawn_valid(sv), .spawn_ready(sready), .spawn_x(sx), .spawn_y(sy), .spawn_up(sup),
    .ship_x(shx), .ship_y(shy), .proj_x(px), .proj_y(py), .proj_active(pact),
    .hit_pulse(hp), .vidas(vid), .perdeu(perd));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, dut_hits = 0;
  always @(negedge clk) if (hp === 1'b1) dut_hits++;

  // ---------------- reference model (slot lists, plain arithmetic) -------
  bit m_act[N]; bit m_up[N]; int m_x[N]; int m_y[N];
  int m_cnt, m_ticks = 0, m_hits = 0, m_vidas;
  bit m_first, m_perdeu;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_up[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_cnt = 0; m_first = 1; m_vidas = LV; m_perdeu = 0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m_act[i]) return 0;
    return 1;
  endfunction

  // Pool is idle from reset until the first tick, and N+2 counts after a wrap.
  function automatic bit m_ready();
    return !pausa && !m_perdeu && !m_full() && (m_cnt != TD - 1) && (m_first || m_cnt >= N + 2);
  endfunction

  function automatic void m_tick();
    m_ticks++;
    for (int i = 0; i < N; i++) if (m_act[i]) begin
      if (m_up[i]) begin if (m_y[i] < SPD) m_act[i] = 0; else m_y[i] -= SPD; end
      else begin if (m_y[i] + SPD > YM) m_act[i] = 0; else m_y[i] += SPD; end
    end
    for (int i = 0; i < N; i++)
      if (m_act[i] && !m_up[i] && m_x[i] >= shx && m_x[i] < shx + SW &&
          m_y[i] >= shy && m_y[i] < shy + SH) begin
        m_act[i] = 0; m_hits++;
        if (LIVES_EN && m_vidas > 0) begin m_vidas--; if (m_vidas == 0) m_perdeu = 1; end
      end
  endfunction

  function automatic void m_edge();
    if (rst || rein) begin m_reset(); return; end
    if (sv && m_ready()) begin
      for (int i = 0; i < N; i++) if (!m_act[i]) begin
        m_act[i] = 1; m_x[i] = sx; m_y[i] = sy; m_up[i] = sup; break;
      end
    end
    if (!pausa && !m_perdeu) begin
      if (m_cnt == TD - 1) begin m_cnt = 0; m_first = 0; m_tick(); end
      else m_cnt++;
    end
  endfunction

  // ---------------- helpers ---------------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); m_edge(); #1;
  endtask

  task automatic spawn(input int x, input int y, input bit up, input string nm);
    sx = W'(x); sy = W'(y); sup = up; sv = 1'b1; #1;
    chk({nm, " ready"}, sready, m_ready());
    step(); sv = 1'b0;
  endtask

  task automatic restart();
    rein = 1'b1; #1;
    chk("ready during restart", sready, 0);
    step(); rein = 1'b0;
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s act%0d", nm, i), pact[i], m_act[i]);
      if (m_act[i]) begin
        chk($sformatf("%s x%0d", nm, i), px[i*W +: W], m_x[i]);
        chk($sformatf("%s y%0d", nm, i), py[i*W +: W], m_y[i]);
      end
    end
    chk({nm, " vidas"}, vid, m_vidas);
    chk({nm, " perdeu"}, perd, m_perdeu);
    chk({nm, " hits"}, dut_hits, m_hits);
  endtask

  // Advance k ticks and stop in the idle window (or after the scan on game-over).
  task automatic run_ticks(input int k, input string nm);
    int target = m_ticks + k;
    int budget = (k + 2) * TD;
    while (budget > 0) begin
      if (m_ticks >= target) begin
        if (m_perdeu) begin repeat (N + 4) step(); break; end
        if (m_cnt == 12) break;
      end
      step(); budget--;
    end
    if (budget == 0) begin checks++; errors++; $display("FAIL %s: tick timeout", nm); end
  endtask

  typedef struct { int x; int y; bit up; int ticks; bit e_act; int e_y; } vec_t;
  vec_t tv[7];

  initial begin
    int n, h_base, budget;
    rst = 1; rein = 0; pausa = 0; sv = 0; sup = 0; sx = 0; sy = 0; shx = 600; shy = 0;
    m_reset();
    repeat (2) @(posedge clk); #1;
    chk("reset active", pact, 0); chk("reset x", px, 0); chk("reset y", py, 0);
    chk("reset hit", hp, 0); chk("reset vidas", vid, LV); chk("reset perdeu", perd, 0);
    chk("reset ready", sready, 0);
    rst = 0; #1;
    chk("ready after reset", sready, 1);

    // Motion and edge vectors, each into an empty pool with the ship far away.
    tv[0] = '{x:100, y:50,  up:1'b0, ticks:3, e_act:1'b1, e_y:56};
    tv[1] = '{x:300, y:478, up:1'b0, ticks:1, e_act:1'b0, e_y:0};
    tv[2] = '{x:300, y:477, up:1'b0, ticks:1, e_act:1'b1, e_y:479};
    tv[3] = '{x:300, y:1,   up:1'b1, ticks:1, e_act:1'b0, e_y:0};
    tv[4] = '{x:300, y:2,   up:1'b1, ticks:1, e_act:1'b1, e_y:0};
    tv[5] = '{x:300, y:0,   up:1'b1, ticks:1, e_act:1'b0, e_y:0};
    tv[6] = '{x:5,   y:100, up:1'b1, ticks:4, e_act:1'b1, e_y:92};
    for (int v = 0; v < 7; v++) begin
      restart();
      spawn(tv[v].x, tv[v].y, tv[v].up, $sformatf("vec%0d", v));
      run_ticks(tv[v].ticks, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d active", v), pact[0], tv[v].e_act);
      if (tv[v].e_act) chk($sformatf("vec%0d y", v), py[W-1:0], tv[v].e_y);
      check_all($sformatf("vec%0d", v));
    end

    // Tick-to-idle latency: ready is low from the wrap cycle until IDLE.
    restart();
    spawn(100, 50, 0, "lat");
    budget = 40;
    while (m_cnt != TD - 1 && budget > 0) begin step(); budget--; end
    n = 0;
    while (sready === 1'b0 && n < 40) begin n++; step(); end
    chk("latency ready-low cycles", n, N + 3);

    // Fill the pool, drop a 9th request, refill the freed slot 3.
    restart();
    for (int i = 0; i < N; i++) spawn(10 + i * 20, (i == 3) ? 1 : 100, i == 3, $sformatf("fill%0d", i));
    chk("full ready", sready, 0);
    spawn(555, 55, 0, "ninth");
    check_all("full");
    run_ticks(1, "despawn3");
    chk("slot3 freed", pact[3], 0);
    spawn(333, 200, 0, "refill");
    chk("refill slot3 active", pact[3], 1);
    chk("refill slot3 x", px[3*W +: W], 333);
    check_all("refill");

    // Two enemy hits plus an up shot inside the box.
    restart();
    shx = 200; shy = 400;
    spawn(210, 399, 0, "hitA"); spawn(244, 405, 0, "hitB"); spawn(220, 410, 1, "upin");
    h_base = dut_hits;
    run_ticks(1, "hits");
    chk("two hit pulses", dut_hits - h_base, 2);
    chk("vidas after two hits", vid, LIVES_EN ? 1 : 3);
    chk("up shot survives", pact[2], 1);
    check_all("hits");

    // Three hits: game over freezes motion; restart recovers.
    restart();
    spawn(210, 400, 0, "go0"); spawn(220, 401, 0, "go1"); spawn(230, 402, 0, "go2");
    spawn(50, 100, 0, "go3");
    run_ticks(1, "gameover");
    chk("gameover vidas", vid, LIVES_EN ? 0 : 3);
    chk("gameover perdeu", perd, LIVES_EN);
    chk("gameover ready", sready, m_ready());
    repeat (3 * TD) step();
    chk("gameover motion y", py[3*W +: W], LIVES_EN ? 102 : 108);
    check_all("gameover");
    restart();
    chk("restart vidas", vid, LV); chk("restart perdeu", perd, 0); chk("restart active", pact, 0);

    // Pause holds positions.
    shx = 600; shy = 0;
    spawn(100, 100, 0, "pause");
    run_ticks(1, "prepause");
    pausa = 1;
    repeat (3 * TD) step();
    chk("paused y", py[W-1:0], 102);
    check_all("paused");
    pausa = 0;

    // Reset while a hit pulse is up in SCAN.
    shx = 90; shy = 95;
    h_base = m_hits;
    budget = 40;
    while (!(m_cnt == 3 && !m_first) && budget > 0) begin step(); budget--; end
    chk("pulse before reset", hp, 1);
    rst = 1; #1;
    chk("midscan active", pact, 0); chk("midscan x", px, 0); chk("midscan y", py, 0);
    chk("midscan hit", hp, 0); chk("midscan vidas", vid, LV); chk("midscan perdeu", perd, 0);
    chk("midscan ready", sready, 0);
    m_hits = h_base;  // the aborted scan's pulse never reaches a full cycle
    step(); rst = 0; #1;
    check_all("after reset");

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      if (m_perdeu) restart();
      shx = W'($urandom_range(0, 595)); shy = W'($urandom_range(350, 460));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        int x, y, sel;
        x = $urandom_range(0, 1) ? shx + $urandom_range(0, SW) : $urandom_range(0, 639);
        sel = $urandom_range(0, 3);
        y = (sel == 0) ? $urandom_range(0, 479) : (sel == 1) ? shy - $urandom_range(0, 4) :
            (sel == 2) ? $urandom_range(474, 479) : $urandom_range(0, 3);
        spawn(x, y, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", r));
      end
      if ($urandom_range(0, 3) == 0) begin
        pausa = 1; repeat ($urandom_range(1, 20)) step(); pausa = 0;
      end
      run_ticks(1, $sformatf("rnd%0d", r));
      check_all($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
